// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: one small in-order result FIFO per functional unit.
// Non-empty FIFO heads are granted round-robin onto the scoreboard writeback ports.
module wb_port_arbiter #(
    parameter int unsigned NR_REQ        = 4,
    parameter int unsigned NR_PORTS      = 2,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NR_REQ-1:0]                 req_valid_i,
    output logic [NR_REQ-1:0]                 req_ready_o,
    input  logic [NR_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i,
    input  logic [NR_REQ*XLEN-1:0]            req_data_i,
    input  logic [NR_REQ-1:0]                 req_ex_valid_i,
    output logic [NR_PORTS-1:0]               wb_valid_o,
    output logic [NR_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [NR_PORTS*XLEN-1:0]          wb_data_o,
    output logic [NR_PORTS-1:0]               wb_ex_valid_o,
    output logic [NR_REQ-1:0]                 pending_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(NR_REQ);

    logic [TRANS_ID_BITS-1:0] id_mem_q   [NR_REQ][FIFO_DEPTH];
    logic [XLEN-1:0]          data_mem_q [NR_REQ][FIFO_DEPTH];
    logic                     ex_mem_q   [NR_REQ][FIFO_DEPTH];

    logic [PTR_W-1:0] head_q  [NR_REQ];
    logic [PTR_W-1:0] head_d  [NR_REQ];
    logic [PTR_W-1:0] tail_q  [NR_REQ];
    logic [PTR_W-1:0] tail_d  [NR_REQ];
    logic [CNT_W-1:0] count_q [NR_REQ];
    logic [CNT_W-1:0] count_d [NR_REQ];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NR_REQ-1:0]   push, pop;
    logic [IDX_W-1:0]    port_src [NR_PORTS];
    logic [NR_PORTS-1:0] port_used;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    last_idx;
    int                  n_grant;

    // Readiness looks only at the registered count, so a full FIFO never reuses a slot freed this cycle.
    always_comb begin
        for (int r = 0; r < NR_REQ; r++) begin
            req_ready_o[r] = !flush_i && (count_q[r] != CNT_W'(FIFO_DEPTH));
            pending_o[r]   = (count_q[r] != '0);
        end
        push = req_valid_i & req_ready_o;
    end

    // Round-robin scan starting at rr_ptr_q; the k-th non-empty requester found drives port k.
    always_comb begin
        pop       = '0;
        port_used = '0;
        n_grant   = 0;
        last_idx  = '0;
        cand      = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            port_src[p] = '0;
        end
        for (int i = 0; i < NR_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NR_REQ);
            if (!flush_i && (count_q[cand] != '0) && (n_grant < NR_PORTS)) begin
                pop[cand] = 1'b1;
                for (int p = 0; p < NR_PORTS; p++) begin
                    if (n_grant == p) begin
                        port_src[p]  = cand;
                        port_used[p] = 1'b1;
                    end
                end
                last_idx = cand;
                n_grant  = n_grant + 1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (n_grant != 0) begin
            rr_ptr_d = IDX_W'((int'(last_idx) + 1) % NR_REQ);
        end
    end

    always_comb begin
        for (int r = 0; r < NR_REQ; r++) begin
            count_d[r] = count_q[r] + CNT_W'(push[r]) - CNT_W'(pop[r]);
            head_d[r]  = head_q[r] + PTR_W'(pop[r]);
            tail_d[r]  = tail_q[r] + PTR_W'(push[r]);
            if (flush_i) begin
                count_d[r] = '0;
                head_d[r]  = '0;
                tail_d[r]  = '0;
            end
        end
    end

    always_comb begin
        wb_valid_o    = '0;
        wb_trans_id_o = '0;
        wb_data_o     = '0;
        wb_ex_valid_o = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (port_used[p]) begin
                wb_valid_o[p] = 1'b1;
                wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] =
                    id_mem_q[port_src[p]][head_q[port_src[p]]];
                wb_data_o[p*XLEN +: XLEN] = data_mem_q[port_src[p]][head_q[port_src[p]]];
                wb_ex_valid_o[p] = ex_mem_q[port_src[p]][head_q[port_src[p]]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int r = 0; r < NR_REQ; r++) begin
                head_q[r]  <= '0;
                tail_q[r]  <= '0;
                count_q[r] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int r = 0; r < NR_REQ; r++) begin
                head_q[r]  <= head_d[r];
                tail_q[r]  <= tail_d[r];
                count_q[r] <= count_d[r];
            end
        end
    end

    // Payload storage needs no reset: entries are only read while the count says they are live.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NR_REQ; r++) begin
            if (push[r]) begin
                id_mem_q[r][tail_q[r]]   <= req_trans_id_i[r*TRANS_ID_BITS +: TRANS_ID_BITS];
                data_mem_q[r][tail_q[r]] <= req_data_i[r*XLEN +: XLEN];
                ex_mem_q[r][tail_q[r]]   <= req_ex_valid_i[r];
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the scoreboard's NR_PORTS writeback ports among NR_REQ result-producing functional units (multi-cycle FUs, CVXIF, FPU).
- Each requester gets a small in-order result FIFO; heads are granted round-robin onto the ports.
- The scoreboard never back-pressures writeback, so the arbiter owns all result buffering.
- Sits between the EX-stage unit outputs and the scoreboard's trans_id_i / wbdata_i / ex_i / wt_valid_i inputs.

Parameters:
- NR_REQ, 4, number of requesting functional units (>=2).
- NR_PORTS, 2, number of writeback ports driven (1..NR_REQ).
- TRANS_ID_BITS, 3, scoreboard transaction-ID width.
- XLEN, 64, result data width.
- FIFO_DEPTH, 2, entries per requester FIFO (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  controller flush; discards all buffered results.
- req_valid_i  in  NR_REQ  per-requester result valid.
- req_ready_o  out  NR_REQ  per-requester FIFO not full.
- req_trans_id_i  in  NR_REQ*TRANS_ID_BITS  result transaction ID.
- req_data_i  in  NR_REQ*XLEN  result data.
- req_ex_valid_i  in  NR_REQ  result carries an exception.
- wb_valid_o  out  NR_PORTS  writeback valid per port.
- wb_trans_id_o  out  NR_PORTS*TRANS_ID_BITS  writeback transaction ID.
- wb_data_o  out  NR_PORTS*XLEN  writeback data.
- wb_ex_valid_o  out  NR_PORTS  writeback exception flag.
- pending_o  out  NR_REQ  per-requester FIFO non-empty.

Behaviour:
- Reset values: FIFOs empty, rr_ptr_q=0, wb_valid_o=0, pending_o=0, req_ready_o=all-ones.
- All wb_* data outputs are don't-care when the matching wb_valid_o=0; the bench drives them to 0.
- Enqueue: when req_valid_i[r] && req_ready_o[r], the entry {trans_id, data, ex_valid} is written at the tail.
- req_ready_o[r] = (count_q[r] != FIFO_DEPTH), from registered count only. A full FIFO stays not-ready even in a cycle where it dequeues; there is no same-cycle slot reuse.
- Latency: minimum 1 cycle from accepted request to wb_valid_o; there is no bypass path. Order within one requester is strictly preserved.
- Grant: each cycle, scan requesters rr_ptr_q, rr_ptr_q+1, ... modulo NR_REQ.
  - The first NR_PORTS requesters with a non-empty FIFO are granted.
  - The k-th granted requester drives port k, combinationally from its FIFO head.
  - Each granted FIFO pops exactly one entry.
  - Unused ports have wb_valid_o=0.
- Pointer update: rr_ptr_q <= (index of last granted requester + 1) mod NR_REQ; unchanged if nothing is granted.
- Simultaneous push and pop on a non-full FIFO: count unchanged, entry order kept.
- Count arithmetic: count width clog2(FIFO_DEPTH)+1. Head and tail pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Flush, in the cycle flush_i=1:
  - wb_valid_o=0 and req_ready_o=0; no enqueue and no pop.
  - Next cycle: all FIFOs empty, rr_ptr_q=0, pending_o=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); buffered results are lost.
- Invariant: no two ports carry the same trans_id in one cycle. This follows from the upstream guarantee of unique in-flight trans_ids; the bench asserts it.
- pending_o[r] = (count_q[r] != 0).

Test Plan:
- Single request: after reset, r0 pushes id=3, data=0xAA at cycle 0 -> cycle 1: wb_valid_o=01, port0 id=3, data=0xAA; cycle 2: pending_o=0.
- Round-robin fairness: all 4 FIFOs hold one entry, rr_ptr=0, NR_PORTS=2 -> cycle 1 grants r0 (port0) and r1 (port1); cycle 2 grants r2 and r3; rr_ptr=0 afterwards.
- Full/backpressure: r1 pushes 2 entries (ids 1, 2) while ports are busy -> req_ready_o[1]=0; in the pop cycle ready stays 0, becomes 1 the next cycle; writebacks emerge in order id 1 then id 2.
- Flush: three FIFOs non-empty, flush_i=1 for 1 cycle -> no wb_valid_o that cycle or after, req_ready_o=0 during flush, all-ones next cycle, pending_o=0.
- Exception pass-through: r3 pushes id=5 with ex_valid=1 -> port0 shows wb_ex_valid_o=1, id=5 exactly one cycle later.
- Reset mid-stream: assert rst_ni low with two entries buffered -> wb_valid_o=0 and req_ready_o=all-ones immediately; no stale writeback after release.
